// File: rtl/sme_job_sched_if.sv
// rtl/sme_job_sched_if.sv - requester, engine and response signals of sme_job_sched
interface sme_job_sched_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  // requester side
  logic [NREQ-1:0]   rq_req;
  logic [NREQ-1:0]   rq_valid;
  logic [NREQ*8-1:0] rq_data;
  logic [NREQ-1:0]   rq_last;
  logic [NREQ-1:0]   rq_ready;
  logic [NREQ-1:0]   grant;
  // engine side
  logic [7:0]        chardata;
  logic              isstring;
  logic              ispattern;
  logic              sme_valid;
  logic              sme_match;
  logic [4:0]        sme_index;
  logic              sme_rst;
  // response side
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_match;
  logic [4:0]        rsp_index;
  logic              rsp_err;

  // scheduler view
  modport slave (
    input  rq_req, rq_valid, rq_data, rq_last,
    output rq_ready, grant,
    output chardata, isstring, ispattern, sme_rst,
    input  sme_valid, sme_match, sme_index,
    output rsp_valid, rsp_id, rsp_match, rsp_index, rsp_err
  );

  // requesters plus engine view
  modport master (
    output rq_req, rq_valid, rq_data, rq_last,
    input  rq_ready, grant,
    input  chardata, isstring, ispattern, sme_rst,
    output sme_valid, sme_match, sme_index,
    input  rsp_valid, rsp_id, rsp_match, rsp_index, rsp_err
  );
endinterface

// File: rtl/sme_job_sched.sv
// rtl/sme_job_sched.sv - round-robin scheduler sharing one SME engine; WAIT watchdog enabled by SME_SCHED_TIMEOUT_EN
module sme_job_sched #(
  parameter int NREQ        = 2,
  parameter int IDW         = 1,
  parameter int STR_MAX     = 32,
  parameter int PAT_MAX     = 9,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic            clk,
  input  logic            reset,
  sme_job_sched_if.slave  bus
);
  // length counters must hold MAX+1 so overflow is visible without wrapping
  localparam int SLW = $clog2(STR_MAX + 2);
  localparam int PLW = $clog2(PAT_MAX + 2);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam logic [SLW-1:0] SLIM = SLW'(STR_MAX);
  localparam logic [PLW-1:0] PLIM = PLW'(PAT_MAX);

  typedef enum logic [3:0] {
    IDLE, ARB, LOAD_S, LOAD_P, SEND_S, SEND_P, GAP, WAIT, RESP
  } state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  rr_ptr, gid, arb_id, arb_c;
  logic            arb_hit;
  logic [NREQ-1:0] grant_q, rq_ready_w, grant_w;
  logic [7:0]      str_buf [STR_MAX];
  logic [7:0]      pat_buf [PAT_MAX];
  logic [SLW-1:0]  slen, slen_nx, k;
  logic [PLW-1:0]  plen, plen_nx;
  logic            res_match, res_err;
  logic [4:0]      res_index;
  logic [7:0]      sel_byte;
  logic            sel_last, accept, len_err;
  logic            wait_expire, sme_rst_w;
  logic            isstring_w, ispattern_w;
  logic [7:0]      chardata_w;

  // granted requester's lane and the ready it sees
  assign sel_byte   = bus.rq_data[{gid, 3'b000} +: 8];
  assign sel_last   = bus.rq_last[gid];
  assign rq_ready_w = (state == LOAD_S || state == LOAD_P) ? grant_q : '0;
  assign accept     = |(bus.rq_valid & rq_ready_w);
  assign slen_nx    = (slen <= SLIM) ? slen + 1'b1 : slen;
  assign plen_nx    = (plen <= PLIM) ? plen + 1'b1 : plen;
  assign len_err    = (slen == '0) || (plen_nx == '0) || (slen > SLIM) || (plen_nx > PLIM);

  // round-robin search starting one past the last grantee
  always_comb begin
    arb_hit = 1'b0;
    arb_id  = '0;
    arb_c   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      arb_c = IDW'((int'(rr_ptr) + i) % NREQ);
      if (!arb_hit && bus.rq_req[arb_c]) begin
        arb_hit = 1'b1;
        arb_id  = arb_c;
      end
    end
  end

`ifdef SME_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] wait_cnt;

  // counts cycles spent in WAIT; cleared everywhere else
  always_ff @(posedge clk) begin
    if (reset || state != WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  // a result arriving in the expiry cycle beats the watchdog
  assign wait_expire = (state == WAIT) && (wait_cnt == TLIM) && !bus.sme_valid;
  assign sme_rst_w   = wait_expire;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign wait_expire        = 1'b0;
  assign sme_rst_w          = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state and engine strobes; SEND_S flows straight into SEND_P
  always_comb begin
    state_nx    = state;
    isstring_w  = 1'b0;
    ispattern_w = 1'b0;
    chardata_w  = 8'h00;
    case (state)
      IDLE:   if (|bus.rq_req) state_nx = ARB;
      ARB:    state_nx = arb_hit ? LOAD_S : IDLE;
      LOAD_S: if (accept && sel_last) state_nx = LOAD_P;
      LOAD_P: if (accept && sel_last) state_nx = len_err ? RESP : SEND_S;
      SEND_S: begin
        isstring_w = 1'b1;
        chardata_w = str_buf[k[SAW-1:0]];
        if (k == slen - 1'b1) state_nx = SEND_P;
      end
      SEND_P: begin
        ispattern_w = 1'b1;
        chardata_w  = pat_buf[k[PAW-1:0]];
        if (k == SLW'(plen - 1'b1)) state_nx = GAP;
      end
      GAP:    state_nx = WAIT;
      WAIT:   if (bus.sme_valid || wait_expire) state_nx = RESP;
      RESP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // job context: grant, buffers, lengths, replay index and captured result
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      gid       <= '0;
      grant_q   <= '0;
      slen      <= '0;
      plen      <= '0;
      k         <= '0;
      res_match <= 1'b0;
      res_index <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          slen      <= '0;
          plen      <= '0;
          k         <= '0;
          res_match <= 1'b0;
          res_index <= '0;
          res_err   <= 1'b0;
        end
        ARB: if (arb_hit) begin
          gid     <= arb_id;
          rr_ptr  <= arb_id;
          grant_q <= NREQ'(1) << arb_id;
        end
        LOAD_S: if (accept) begin
          if (slen < SLIM) str_buf[slen[SAW-1:0]] <= sel_byte;
          slen <= slen_nx;
        end
        LOAD_P: if (accept) begin
          if (plen < PLIM) pat_buf[plen[PAW-1:0]] <= sel_byte;
          plen <= plen_nx;
          if (sel_last && len_err) res_err <= 1'b1;
        end
        SEND_S: k <= (k == slen - 1'b1) ? '0 : k + 1'b1;
        SEND_P: k <= k + 1'b1;
        WAIT: begin
          if (bus.sme_valid) begin
            res_match <= bus.sme_match;
            res_index <= bus.sme_index;
          end else if (wait_expire) begin
            res_err <= 1'b1;
          end
        end
        RESP: grant_q <= '0;
        default: ;
      endcase
    end
  end

  assign grant_w       = (state == ARB && arb_hit) ? (NREQ'(1) << arb_id) : grant_q;
  assign bus.grant     = grant_w;
  assign bus.rq_ready  = rq_ready_w;
  assign bus.isstring  = isstring_w;
  assign bus.ispattern = ispattern_w;
  assign bus.chardata  = chardata_w;
  assign bus.sme_rst   = sme_rst_w;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = (state == RESP) ? gid : '0;
  assign bus.rsp_err   = (state == RESP) && res_err;
  assign bus.rsp_match = (state == RESP) && res_match && !res_err;
  assign bus.rsp_index = (state == RESP && res_match && !res_err) ? res_index : 5'd0;
endmodule

// File: tb/tb_sme_job_sched.sv
// tb/tb_sme_job_sched.sv - directed bench for sme_job_sched with a cycle-level engine model
module tb_sme_job_sched;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  sme_job_sched_if #(.NREQ(2), .IDW(1)) bus();

  sme_job_sched #(
    .NREQ(2), .IDW(1), .STR_MAX(32), .PAT_MAX(9), .TIMEOUT_CYC(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // per-job observations
  int res_gnt, res_id, res_match, res_index, res_err, res_seen, res_abort;
  int res_ns, res_np, res_both, res_bad, res_first_s, res_last_s, res_first_p, res_last_p;
  int res_gap, res_rst_n, res_rst_cyc, res_rsp_cyc;
  int post_strobe, post_grant, post_rsp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.rq_req    = '0;
    bus.rq_valid  = '0;
    bus.rq_data   = '0;
    bus.rq_last   = '0;
    bus.sme_valid = 1'b0;
    bus.sme_match = 1'b0;
    bus.sme_index = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Serves one job for whichever requester is granted, plays the engine and records what it saw.
  task automatic serve(input string s, input string p, input bit slow, input bit em,
                       input logic [4:0] ei, input bit silent, input bit stray, input bit rst_in_pat);
    int cyc, g, phase, idx, slow_ctr, eng_cnt;
    bit drove, rdy, armed, fired, saw;
    logic [7:0] b;
    cyc = 0; g = -1; phase = 0; idx = 0; slow_ctr = 0; eng_cnt = 0;
    drove = 0; rdy = 0; armed = 0; fired = 0; saw = 0;
    res_gnt = -1; res_id = -1; res_match = -1; res_index = -1; res_err = -1;
    res_seen = 0; res_abort = 0; res_ns = 0; res_np = 0; res_both = 0; res_bad = 0;
    res_first_s = -1; res_last_s = -1; res_first_p = -1; res_last_p = -1;
    res_gap = -1; res_rst_n = 0; res_rst_cyc = -1; res_rsp_cyc = -1;
    while (!res_seen && !res_abort && cyc < 3000) begin
      @(posedge clk);
      #1 cyc++;
      if (bus.isstring && bus.ispattern) res_both++;
      if (bus.isstring) begin
        if (res_first_s < 0) res_first_s = cyc;
        res_last_s = cyc;
        if (res_ns < s.len() && bus.chardata != s[res_ns]) res_bad++;
        res_ns++;
        saw = 1;
      end
      if (bus.ispattern) begin
        if (res_first_p < 0) res_first_p = cyc;
        res_last_p = cyc;
        if (res_np < p.len() && bus.chardata != p[res_np]) res_bad++;
        res_np++;
        saw = 1;
      end
      if (bus.sme_rst) begin
        res_rst_n++;
        res_rst_cyc = cyc;
      end
      if (bus.rsp_valid) begin
        res_seen    = 1;
        res_rsp_cyc = cyc;
        res_id      = int'(bus.rsp_id);
        res_match   = int'(bus.rsp_match);
        res_index   = int'(bus.rsp_index);
        res_err     = int'(bus.rsp_err);
      end
      if (g < 0 && bus.grant != '0) begin
        g = bus.grant[1] ? 1 : 0;
        res_gnt = int'(bus.grant);
      end
      if (rst_in_pat && bus.ispattern) begin
        reset = 1'b1;
        bus.rq_valid = '0;
        bus.rq_last  = '0;
        @(posedge clk);
        #1;
        post_strobe = int'(bus.isstring | bus.ispattern);
        post_grant  = int'(bus.grant);
        post_rsp    = int'(bus.rsp_valid);
        reset = 1'b0;
        res_abort = 1;
      end else begin
        if (g >= 0) begin
          if (drove && rdy) begin
            idx++;
            if (phase == 0 && idx == s.len()) begin
              phase = 1;
              idx = 0;
            end else if (phase == 1 && idx == p.len()) begin
              phase = 2;
            end
          end
          rdy   = bus.rq_ready[g];
          drove = (phase < 2) && (!slow || slow_ctr == 0);
          slow_ctr = (slow_ctr == 2) ? 0 : slow_ctr + 1;
          b = (phase == 0) ? s[idx] : (phase == 1) ? p[idx] : 8'h00;
          bus.rq_valid = '0;
          bus.rq_data  = '0;
          bus.rq_last  = '0;
          if (drove) begin
            bus.rq_valid[g]       = 1'b1;
            bus.rq_data[g*8 +: 8] = b;
            bus.rq_last[g]        = (phase == 0) ? (idx == s.len() - 1) : (idx == p.len() - 1);
          end
        end
        bus.sme_valid = 1'b0;
        bus.sme_match = 1'b0;
        bus.sme_index = '0;
        if (saw && !armed && !bus.isstring && !bus.ispattern) begin
          armed   = 1;
          res_gap = cyc;
          eng_cnt = 2;
          if (stray) begin
            bus.sme_valid = 1'b1;
            bus.sme_index = 5'd31;
          end
        end else if (armed && !fired && !silent) begin
          if (eng_cnt == 1) begin
            bus.sme_valid = 1'b1;
            bus.sme_match = em;
            bus.sme_index = ei;
            fired = 1;
          end else begin
            eng_cnt--;
          end
        end
      end
    end
    bus.rq_valid  = '0;
    bus.rq_last   = '0;
    bus.rq_data   = '0;
    bus.sme_valid = 1'b0;
    bus.sme_match = 1'b0;
    bus.sme_index = '0;
    if (!rst_in_pat) check_val("rsp_seen", res_seen, 1);
  endtask

  initial begin
    string s32, s33;
    int exp_gnt [4];
    s32 = "abcdefghijklmnopqrstuvwxyz012345";
    s33 = {s32, "6"};
    exp_gnt[0] = 2; exp_gnt[1] = 1; exp_gnt[2] = 2; exp_gnt[3] = 1;

    // reset state
    do_reset();
    @(posedge clk);
    #1;
    check_val("rst_grant", bus.grant, 0);
    check_val("rst_ready", bus.rq_ready, 0);
    check_val("rst_strobes", {bus.isstring, bus.ispattern, bus.sme_rst}, 0);
    check_val("rst_chardata", bus.chardata, 0);
    check_val("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_match, bus.rsp_index, bus.rsp_err}, 0);

    // basic job, with a stray engine pulse during GAP that must be ignored
    bus.rq_req = 2'b01;
    serve("abc abd", "abd", 0, 1, 5'd4, 0, 1, 0);
    bus.rq_req = 2'b00;
    check_val("t1_grant", res_gnt, 1);
    check_val("t1_nstr", res_ns, 7);
    check_val("t1_npat", res_np, 3);
    check_val("t1_nogap", res_first_p, res_last_s + 1);
    check_val("t1_span", res_last_p - res_first_s + 1, 10);
    check_val("t1_latency", res_gap - res_first_s, 10);
    check_val("t1_both", res_both, 0);
    check_val("t1_data", res_bad, 0);
    check_val("t1_rsp", {res_id[7:0], res_match[7:0], res_index[7:0], res_err[7:0]}, 32'h00_01_04_00);
    check_val("t1_sme_rst", res_rst_n, 0);
    @(posedge clk);
    #1 check_val("t1_grant_drop", bus.grant, 0);

    // round robin from reset with both requesting
    do_reset();
    bus.rq_req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      serve("xy", "y", 0, j[0], 5'(5 + j), 0, 0, 0);
      check_val("rr_grant", res_gnt, exp_gnt[j]);
      check_val("rr_id", res_id, (exp_gnt[j] == 2) ? 1 : 0);
      check_val("rr_match", res_match, j % 2);
      check_val("rr_index", res_index, (j % 2 == 1) ? 5 + j : 0);
    end
    bus.rq_req = 2'b00;

    // pattern too long
    bus.rq_req = 2'b10;
    serve("hello", "^abcdefgh$", 0, 1, 5'd3, 0, 0, 0);
    bus.rq_req = 2'b00;
    check_val("t3_strobes", res_ns + res_np, 0);
    check_val("t3_rsp", {res_id[7:0], res_match[7:0], res_index[7:0], res_err[7:0]}, 32'h01_00_00_01);

    // slow source, burst still contiguous
    bus.rq_req = 2'b01;
    serve("the quick fox", "^fox$", 1, 1, 5'd10, 0, 0, 0);
    bus.rq_req = 2'b00;
    check_val("t4_nstr", res_ns, 13);
    check_val("t4_npat", res_np, 5);
    check_val("t4_span", res_last_p - res_first_s + 1, 18);
    check_val("t4_nogap", res_first_p, res_last_s + 1);
    check_val("t4_data", res_bad, 0);
    check_val("t4_rsp", {res_id[7:0], res_match[7:0], res_index[7:0], res_err[7:0]}, 32'h00_01_0a_00);

    // exact maximum lengths are legal
    bus.rq_req = 2'b01;
    serve(s32, "^abcdefg$", 0, 1, 5'd17, 0, 0, 0);
    bus.rq_req = 2'b00;
    check_val("t5_nstr", res_ns, 32);
    check_val("t5_npat", res_np, 9);
    check_val("t5_data", res_bad, 0);
    check_val("t5_rsp", {res_id[7:0], res_match[7:0], res_index[7:0], res_err[7:0]}, 32'h00_01_11_00);

    // one string byte too many
    bus.rq_req = 2'b01;
    serve(s33, "ab", 0, 1, 5'd2, 0, 0, 0);
    bus.rq_req = 2'b00;
    check_val("t6_strobes", res_ns + res_np, 0);
    check_val("t6_rsp", {res_id[7:0], res_match[7:0], res_index[7:0], res_err[7:0]}, 32'h00_00_00_01);

    // reset in SEND_P, then a fresh job
    bus.rq_req = 2'b01;
    serve("abc", "bc", 0, 1, 5'd1, 0, 0, 1);
    bus.rq_req = 2'b00;
    check_val("t7_aborted", res_abort, 1);
    check_val("t7_strobes", post_strobe, 0);
    check_val("t7_grant", post_grant, 0);
    check_val("t7_rsp", post_rsp + res_seen, 0);
    bus.rq_req = 2'b01;
    serve("abc abd", "abd", 0, 1, 5'd4, 0, 0, 0);
    bus.rq_req = 2'b00;
    check_val("t7_after", {res_id[7:0], res_match[7:0], res_index[7:0], res_err[7:0]}, 32'h00_01_04_00);

`ifdef SME_SCHED_TIMEOUT_EN
    // silent engine trips the watchdog
    bus.rq_req = 2'b01;
    serve("ab", "b", 0, 1, 5'd1, 1, 0, 0);
    bus.rq_req = 2'b00;
    check_val("t8_rst_count", res_rst_n, 1);
    check_val("t8_rst_cycle", res_rst_cyc, res_gap + 16);
    check_val("t8_rsp_cycle", res_rsp_cyc, res_rst_cyc + 1);
    check_val("t8_rsp", {res_id[7:0], res_match[7:0], res_index[7:0], res_err[7:0]}, 32'h00_00_00_01);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
